// File: rtl/instr_decode.sv
// instr_decode: falling-edge instruction decoder with EXEC/TARGET/SKIP sequencing.
// Define IFD_RET_STACK_EN to add a call/return stack; otherwise RTN skips the following word.
module instr_decode #(
   parameter int SIZE_LOG    = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SIZE_LOG-1:0] pc_addr,
   input  logic [7:0]          mem_data,
   input  logic                rr,
   output logic                pc_write,
   output logic [SIZE_LOG-1:0] pc_target,
   output logic                instr_valid,
   output logic [3:0]          instr_op,
   output logic [3:0]          instr_operand,
   output logic                jmp_flag,
   output logic                rtn_flag,
   output logic                flag_o,
   output logic                flag_f,
   output logic                stack_err
);
   localparam logic [1:0] EXEC = 2'd0, TARGET = 2'd1, SKIP = 2'd2;
   logic [1:0]          state_q, state_d;
   logic                valid_q, valid_d;
   logic [3:0]          op_q, op_d, operand_q, operand_d;
   logic                jmp_q, jmp_d, rtn_q, rtn_d, fo_q, fo_d, ff_q, ff_d;
   logic                pcw;
   logic [SIZE_LOG-1:0] tgt;
   logic [3:0]          op;
   assign op = mem_data[7:4];
`ifdef IFD_RET_STACK_EN
   localparam int SPW = $clog2(STACK_DEPTH + 1);
   localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   logic [SIZE_LOG-1:0] stk_q [STACK_DEPTH];
   logic [SPW-1:0]      sp_q, sp_d;
   logic                call_q, call_d, err_q, err_d, push, empty, full;
   logic [IW-1:0]       top_idx, push_idx;
   assign empty    = sp_q == '0;
   assign full     = sp_q == SPW'(STACK_DEPTH);
   assign top_idx  = IW'(sp_q - 1'b1);
   assign push_idx = IW'(sp_q);
   assign stack_err = err_q;
`else
   logic unused_pc;
   assign unused_pc = ^pc_addr;
   assign stack_err = 1'b0;
`endif
   always_comb begin
      state_d   = EXEC;
      valid_d   = 1'b0;
      op_d      = op_q;
      operand_d = operand_q;
      jmp_d     = 1'b0;
      rtn_d     = 1'b0;
      fo_d      = 1'b0;
      ff_d      = 1'b0;
      pcw       = 1'b0;
      tgt       = '0;
`ifdef IFD_RET_STACK_EN
      call_d    = call_q;
      sp_d      = sp_q;
      err_d     = err_q;
      push      = 1'b0;
`endif
      case (state_q)
         EXEC: begin
            valid_d   = 1'b1;
            op_d      = op;
            operand_d = mem_data[3:0];
            fo_d      = op == 4'h0;
            ff_d      = op == 4'hF;
            jmp_d     = op == 4'hC;
            rtn_d     = op == 4'hD;
            if (op == 4'hC) begin
               state_d = TARGET;
`ifdef IFD_RET_STACK_EN
               call_d  = mem_data[0];
`endif
            end else if (op == 4'hE) begin
               state_d = rr ? EXEC : SKIP;
            end else if (op == 4'hD) begin
`ifdef IFD_RET_STACK_EN
               if (!empty) begin
                  pcw  = 1'b1;
                  tgt  = stk_q[top_idx];
                  sp_d = sp_q - 1'b1;
               end else begin
                  err_d   = 1'b1;
                  state_d = SKIP;
               end
`else
               state_d = SKIP;
`endif
            end
         end
         TARGET: begin
            pcw = 1'b1;
            tgt = mem_data[SIZE_LOG-1:0];
`ifdef IFD_RET_STACK_EN
            // A full stack drops the return address but the jump still happens.
            if (call_q) begin
               if (full) err_d = 1'b1;
               else begin
                  push = 1'b1;
                  sp_d = sp_q + 1'b1;
               end
            end
`endif
         end
         default: ;
      endcase
   end
   assign pc_write  = pcw & rst;
   assign pc_target = pc_write ? tgt : '0;
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= EXEC;
         valid_q   <= 1'b0;
         op_q      <= '0;
         operand_q <= '0;
         jmp_q     <= 1'b0;
         rtn_q     <= 1'b0;
         fo_q      <= 1'b0;
         ff_q      <= 1'b0;
`ifdef IFD_RET_STACK_EN
         call_q    <= 1'b0;
         sp_q      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         op_q      <= op_d;
         operand_q <= operand_d;
         jmp_q     <= jmp_d;
         rtn_q     <= rtn_d;
         fo_q      <= fo_d;
         ff_q      <= ff_d;
`ifdef IFD_RET_STACK_EN
         call_q    <= call_d;
         sp_q      <= sp_d;
         err_q     <= err_d;
`endif
      end
   end
`ifdef IFD_RET_STACK_EN
   always_ff @(negedge clk) begin
      if (push) stk_q[push_idx] <= pc_addr + 1'b1;
   end
`endif
   assign instr_valid   = valid_q;
   assign instr_op      = op_q;
   assign instr_operand = operand_q;
   assign jmp_flag      = jmp_q;
   assign rtn_flag      = rtn_q;
   assign flag_o        = fo_q;
   assign flag_f        = ff_q;
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed program runs with an external PC, checked each cycle against a word-role model.
module tb_instr_decode;
`ifdef IFD_RET_STACK_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif
   logic       clk = 1'b1;
   logic       rst;
   logic [7:0] pc_addr, mem_data, pc_target;
   logic       rr, pc_write, instr_valid, jmp_flag, rtn_flag, flag_o, flag_f, stack_err;
   logic [3:0] instr_op, instr_operand;
   instr_decode #(.SIZE_LOG(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .mem_data(mem_data), .rr(rr),
      .pc_write(pc_write), .pc_target(pc_target), .instr_valid(instr_valid),
      .instr_op(instr_op), .instr_operand(instr_operand), .jmp_flag(jmp_flag),
      .rtn_flag(rtn_flag), .flag_o(flag_o), .flag_f(flag_f), .stack_err(stack_err)
   );
   always #5 clk = ~clk;
   logic [7:0] mem [256];
   int  pc;
   bit  rst_v, rr_v;
   int  total, bad;
   // Model: role of the next word (jump target / discarded / normal) plus a return-address queue.
   bit       tgt_next, skip_next, call;
   int       stk[$];
   bit       m_err, m_valid, m_jmp, m_rtn, m_fo, m_ff;
   bit [3:0] m_op, m_opnd;
   bit       e_pcw;
   int       e_tgt;
   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at pc %0h t=%0t", nm, act, exp, pc, $time);
      end
   endtask
   function automatic void model_reset();
      tgt_next = 0; skip_next = 0; call = 0; stk.delete(); m_err = 0;
      m_valid = 0; m_op = 0; m_opnd = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
   endfunction
   function automatic void model_comb();
      logic [7:0] w = mem[pc];
      e_pcw = 0; e_tgt = 0;
      if (rst_v) begin
         if (tgt_next) begin e_pcw = 1; e_tgt = w; end
         else if (!skip_next && EN && w[7:4] == 4'hD && stk.size() > 0) begin e_pcw = 1; e_tgt = stk[$]; end
      end
   endfunction
   function automatic void model_edge();
      logic [7:0] w = mem[pc];
      int npc;
      if (!rst_v) begin model_reset(); return; end
      npc = e_pcw ? e_tgt : (pc + 1) % 256;
      m_valid = 0; m_jmp = 0; m_rtn = 0; m_fo = 0; m_ff = 0;
      if (tgt_next) begin
         tgt_next = 0;
         if (EN && call) begin
            if (stk.size() < 4) stk.push_back((pc + 1) % 256);
            else m_err = 1;
         end
      end else if (skip_next) begin
         skip_next = 0;
      end else begin
         m_valid = 1; m_op = w[7:4]; m_opnd = w[3:0];
         m_fo = w[7:4] == 4'h0;
         m_ff = w[7:4] == 4'hF;
         if (w[7:4] == 4'hC) begin m_jmp = 1; call = w[0]; tgt_next = 1; end
         if (w[7:4] == 4'hE && !rr_v) skip_next = 1;
         if (w[7:4] == 4'hD) begin
            m_rtn = 1;
            if (EN && stk.size() > 0) void'(stk.pop_back());
            else begin
               if (EN) m_err = 1;
               skip_next = 1;
            end
         end
      end
      pc = npc;
   endfunction
   task automatic drive();
      pc_addr = 8'(pc); mem_data = mem[pc]; rr = rr_v; rst = rst_v;
      #1;
      model_comb();
      chk("pc_write", pc_write, e_pcw);
      chk("pc_target", pc_target, e_tgt);
   endtask
   task automatic tick();
      @(negedge clk);
      model_edge();
      @(posedge clk);
      chk("instr_valid", instr_valid, m_valid);
      if (m_valid) begin
         chk("instr_op", instr_op, m_op);
         chk("instr_operand", instr_operand, m_opnd);
      end
      chk("jmp_flag", jmp_flag, m_jmp);
      chk("rtn_flag", rtn_flag, m_rtn);
      chk("flag_o", flag_o, m_fo);
      chk("flag_f", flag_f, m_ff);
      chk("stack_err", stack_err, m_err);
   endtask
   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin drive(); tick(); end
   endtask
   task automatic restart(input int start);
      rst_v = 0; pc = start; cyc(); rst_v = 1;
   endtask
   initial begin
      total = 0; bad = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h1A; mem[8'h01] = 8'h00; mem[8'h02] = 8'hF3; mem[8'h03] = 8'hE0;
      mem[8'h04] = 8'h81; mem[8'h05] = 8'hC0; mem[8'h06] = 8'h20;
      mem[8'h20] = 8'hC0; mem[8'h21] = 8'h03;
      mem[8'h08] = 8'hE0; mem[8'h09] = 8'hC1; mem[8'h0A] = 8'h35; mem[8'h0B] = 8'hD0;
      mem[8'h0C] = 8'h99; mem[8'h0D] = 8'h27;
      mem[8'h10] = 8'hC1; mem[8'h11] = 8'h40; mem[8'h40] = 8'hD0; mem[8'h12] = 8'h00;
      mem[8'h13] = 8'hD0; mem[8'h14] = 8'h66;
      mem[8'h50] = 8'hC1; mem[8'h51] = 8'h60; mem[8'h60] = 8'hC1; mem[8'h61] = 8'h70;
      mem[8'h70] = 8'hC1; mem[8'h71] = 8'h80; mem[8'h80] = 8'hC1; mem[8'h81] = 8'h90;
      mem[8'h90] = 8'hC1; mem[8'h91] = 8'hA0; mem[8'hA0] = 8'hD0;
      mem[8'h82] = 8'hD0; mem[8'h72] = 8'hD0; mem[8'h62] = 8'hD0; mem[8'h52] = 8'hD0;
      mem[8'h53] = 8'h77; mem[8'h54] = 8'h11;
      model_reset();
      rst_v = 0; rr_v = 0; pc = 0;
      cyc();
      chk("reset_valid", instr_valid, 0);
      chk("reset_op", instr_op, 0);
      chk("reset_err", stack_err, 0);
      rst_v = 1;
      cyc();
      chk("first_valid", instr_valid, 1);
      chk("first_op", instr_op, 4'h1);
      chk("first_operand", instr_operand, 4'hA);
      cyc();
      chk("nopo_flag", flag_o, 1);
      cyc();
      chk("nopf_flag", flag_f, 1);
      chk("nopo_clear", flag_o, 0);
      cyc(2);
      chk("skz_skipped", instr_valid, 0);
      cyc();
      chk("jmp_pulse", jmp_flag, 1);
      drive();
      chk("target_write", pc_write, 1);
      chk("target_addr", pc_target, 8'h20);
      tick();
      chk("target_novalid", instr_valid, 0);
      rr_v = 1;
      cyc(4);
      chk("skz_taken_valid", instr_valid, 1);
      chk("skz_taken_op", instr_op, 4'h8);
      chk("skz_taken_operand", instr_operand, 4'h1);
      cyc(3);
      restart(8'h08);
      rr_v = 0;
      cyc(3);
      chk("skipped_jmp_op", instr_op, 4'h3);
      chk("skipped_jmp_operand", instr_operand, 4'h5);
      cyc();
      chk("rtn_pulse", rtn_flag, 1);
      chk("rtn_empty_err", stack_err, EN);
      cyc();
      chk("rtn_skip", instr_valid, 0);
      cyc();
      chk("after_skip_op", instr_op, 4'h2);
      restart(8'h05);
      cyc();
      drive();
      chk("pre_reset_write", pc_write, 1);
      rst_v = 0;
      drive();
      chk("reset_drops_write", pc_write, 0);
      tick();
      rst_v = 1;
      cyc();
      chk("abandoned_target_valid", instr_valid, 1);
      chk("abandoned_target_op", instr_op, 4'h2);
      chk("abandoned_target_operand", instr_operand, 4'h0);
`ifdef IFD_RET_STACK_EN
      restart(8'h10);
      cyc(2);
      drive();
      chk("ret_write", pc_write, 1);
      chk("ret_addr", pc_target, 8'h12);
      tick();
      chk("ret_pulse", rtn_flag, 1);
      cyc(2);
      chk("ret_now_empty_err", stack_err, 1);
      cyc(2);
      restart(8'h50);
      cyc(8);
      chk("four_calls_no_err", stack_err, 0);
      cyc(2);
      chk("overflow_err", stack_err, 1);
      cyc(5);
      chk("fifth_rtn_pulse", rtn_flag, 1);
      cyc();
      chk("fifth_rtn_skip", instr_valid, 0);
      cyc();
      chk("after_fifth_op", instr_op, 4'h1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 Parameter SIZE_LOG, default 8: program address width; legal range 1..8.
REQ-002 Parameter STACK_DEPTH, default 4: return-stack entries; legal range 1..16.
REQ-003 clk  in  1  single clock; all state updates on falling edge, aligned with the program counter.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 pc_addr  in  SIZE_LOG  current program-counter value.
REQ-006 mem_data  in  8  instruction word at pc_addr: [7:4] opcode, [3:0] operand.
REQ-007 rr  in  1  result-register bit from the logic unit.
REQ-008 pc_write  out  1  combinational load request to the program counter.
REQ-009 pc_target  out  SIZE_LOG  combinational load address to the program counter.
REQ-010 instr_valid  out  1  registered strobe: instr_op/instr_operand hold an executable instruction.
REQ-011 instr_op  out  4  registered opcode.
REQ-012 instr_operand  out  4  registered operand, an I/O or RAM address.
REQ-013 jmp_flag, rtn_flag, flag_o, flag_f  out  1 each  registered one-cycle pulses.
REQ-014 stack_err  out  1  sticky return-stack over/underflow indicator.

Function
REQ-015 FSM states: EXEC (decode word), TARGET (word is jump target), SKIP (discard word); one word consumed per falling edge.
REQ-016 EXEC, any opcode: at edge, instr_valid<=1, instr_op<=mem_data[7:4], instr_operand<=mem_data[3:0]; latency one edge.
REQ-017 EXEC, 0x0 NOPO: flag_o pulse; 0xF NOPF: flag_f pulse.
REQ-018 EXEC, 0xC JMP: jmp_flag pulse; latch operand bit0 as call bit; next state TARGET.
REQ-019 TARGET: pc_write=1, pc_target=mem_data[SIZE_LOG-1:0]; instr_valid<=0; next state EXEC.
REQ-020 EXEC, 0xE SKZ: if rr==0 at the edge, next state SKIP; else EXEC.
REQ-021 EXEC, 0xD RTN: rtn_flag pulse; behaviour per REQ-029/REQ-030.
REQ-022 SKIP: word discarded, instr_valid<=0, no flags, no pc_write; next state EXEC.
REQ-023 Exactly one word skipped; a skipped JMP leaves its following target word to be decoded as an instruction.
REQ-024 pc_write=0 in every case not listed; pc_target=0 whenever pc_write=0.
REQ-025 Flag pulses and instr_valid deassert on the edge after assertion unless re-triggered.

Reset
REQ-026 rst low: state EXEC; stack pointer 0; instr_valid, instr_op, instr_operand, all flags and stack_err 0.
REQ-027 rst low forces pc_write=0 combinationally, including mid-TARGET; a pending jump is abandoned.
REQ-028 Release of rst takes effect at the next falling edge; the first word decoded is the word at pc_addr.

Configuration
REQ-029 With IFD_RET_STACK_EN defined:
- TARGET with call bit set pushes pc_addr+1 (modulo 2^SIZE_LOG).
- RTN with stack non-empty: pc_write=1, pc_target=top; pop at the edge; next state EXEC.
- RTN with stack empty: stack_err<=1 and behave as REQ-030.
- Push when full: push dropped, stack_err<=1; the jump still occurs.
REQ-030 Without IFD_RET_STACK_EN: no stack storage; the call bit is ignored; RTN always sets next state SKIP (classic skip-after-return); stack_err tied 0.

Verification
REQ-031 Reset, word 0x1A at pc 0x00 -> next edge instr_valid=1, instr_op=0x1, instr_operand=0xA.
REQ-032 0x05=0xC0, 0x06=0x20 -> jmp_flag pulse after 0x05; pc_write=1, pc_target=0x20 while pc=0x06; no instr_valid for 0x06.
REQ-033 0x03=0xE0, 0x04=0x81 with rr=0 -> 0x04 yields no instr_valid; repeated with rr=1 -> instr_op=0x8, instr_operand=0x1.
REQ-034 EN: 0x10=0xC1, 0x11=0x40, 0x40=0xD0 -> RTN drives pc_write=1, pc_target=0x12; stack empty afterwards.
REQ-035 EN, STACK_DEPTH=4: five nested calls -> stack_err=1 after the fifth; the fifth RTN (stack empty) skips one word.
REQ-036 rst low while in TARGET -> pc_write drops immediately; after release the target word decodes as an instruction.
